// File: rtl/data_memory_pipe.sv
// Pipelined synchronous-read data memory with byte strobes,
// valid/ready request/response ports and out-of-range reporting.
module data_memory_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    err_sticky
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int L  = READ_LATENCY;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  advance;
  logic                  accept;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [L-1:0]          sv;
  logic [L-1:0]          se;
  logic [DATA_WIDTH-1:0] sd [L];

  logic [L-1:0]          src_v;
  logic [L-1:0]          src_e;
  logic [DATA_WIDTH-1:0] src_d [L];

  assign advance  = ~rsp_valid | rsp_ready;
  assign req_ready = advance & ~reset;
  assign accept   = req_valid & req_ready;
  assign in_range = {1'b0, req_addr} < DEPTH_W;
  assign rd_word  = in_range ? mem[req_addr] : '0;

  assign rsp_valid = sv[L-1];
  assign rsp_rdata = sd[L-1];
  assign rsp_err   = se[L-1];

  always_comb begin
    src_v    = '0;
    src_e    = '0;
    src_d    = '{default: '0};
    src_v[0] = accept & ~req_write;
    src_e[0] = ~in_range;
    src_d[0] = rd_word;
    for (int i = 1; i < L; i++) begin
      src_v[i] = sv[i-1];
      src_e[i] = se[i-1];
      src_d[i] = sd[i-1];
    end
  end

  // Last stage only loads on a valid entry so outputs hold between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      sv         <= '0;
      se         <= '0;
      sd         <= '{default: '0};
      err_sticky <= 1'b0;
    end else begin
      if (accept & ~in_range)
        err_sticky <= 1'b1;
      if (advance) begin
        for (int i = 0; i < L; i++) begin
          sv[i] <= src_v[i];
          if (i < L - 1 || src_v[i]) begin
            sd[i] <= src_d[i];
            se[i] <= src_e[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept & req_write & in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b])
          mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

endmodule
